// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU op codes and the ID/EX control bundle.
// Used by id_ex_stage and reg_file.
package mips_pkg;

  localparam int unsigned RegAddrW = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b11
  } alu_op_e;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic [RegAddrW-1:0] rd;
    alu_op_e             alu_op;
    logic [5:0]          funct;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    rd:        '0,
    alu_op:    ALUOP_ADD,
    funct:     '0
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// IF/ID input, writeback and ID/EX output bundle of the decode stage.
// master drives instructions/writeback, slave is the decode stage itself.
interface id_ex_stage_if #(
  parameter int unsigned WIDTH = 32
);
  import mips_pkg::*;

  logic [31:0]         instr;
  logic                if_valid;
  logic                stall;
  logic                flush;
  logic                wb_we;
  logic [RegAddrW-1:0] wb_addr;
  logic [WIDTH-1:0]    wb_data;

  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [1:0]          Alu_op;
  logic [5:0]          funct;
  logic [WIDTH-1:0]    ex_store_data;
  logic [RegAddrW-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_valid;

  modport master (
    output instr, if_valid, stall, flush, wb_we, wb_addr, wb_data,
    input  a, b, Alu_op, funct, ex_store_data, ex_rd, ex_reg_write, ex_valid
  );

  modport slave (
    input  instr, if_valid, stall, flush, wb_we, wb_addr, wb_data,
    output a, b, Alu_op, funct, ex_store_data, ex_rd, ex_reg_write, ex_valid
  );

endinterface

// File: rtl/reg_file.sv
// NREGS x WIDTH register file: two async read ports, one sync write port, r0 reads zero.
// ID_EX_BYPASS_EN makes a same-cycle write visible on the read ports (write-through).
module reg_file
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic [WIDTH-1:0]    rdata_a_o,
  output logic [WIDTH-1:0]    rdata_b_o,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0]    wdata_i
);

  logic [NREGS-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        wr_en;

  assign wr_en = we_i && (waddr_i != '0) && (32'(waddr_i) < NREGS);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if ((raddr_a_i != '0) && (32'(raddr_a_i) < NREGS)) begin
      rdata_a_o = mem_q[raddr_a_i];
    end
    if ((raddr_b_i != '0) && (32'(raddr_b_i) < NREGS)) begin
      rdata_b_o = mem_q[raddr_b_i];
    end
`ifdef ID_EX_BYPASS_EN
    // wr_en already excludes r0, so r0 stays zero even when bypassing
    if (wr_en && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
    if (wr_en && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
`endif
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand stage: register file read, instruction decode and the ID/EX register.
// Optional write-through read of the register file is enabled with ID_EX_BYPASS_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  logic [5:0]          opcode;
  logic [RegAddrW-1:0] rs, rt, rd_field;
  logic [WIDTH-1:0]    rs_val, rt_val, imm_sext;

  assign opcode   = bus.instr[31:26];
  assign rs       = bus.instr[25:21];
  assign rt       = bus.instr[20:16];
  assign rd_field = bus.instr[15:11];
  assign imm_sext = {{(WIDTH-16){bus.instr[15]}}, bus.instr[15:0]};

  reg_file #(
    .NREGS(NREGS),
    .WIDTH(WIDTH)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .raddr_a_i(rs),
    .raddr_b_i(rt),
    .rdata_a_o(rs_val),
    .rdata_b_o(rt_val),
    .we_i     (bus.wb_we),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data)
  );

  ex_ctrl_t         dec_ctrl;
  logic [WIDTH-1:0] dec_b;

  // Unknown opcodes become a valid NOP: control of a bubble, operand A still rs.
  always_comb begin
    dec_ctrl       = EX_CTRL_BUBBLE;
    dec_ctrl.valid = 1'b1;
    dec_b          = '0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.alu_op    = ALUOP_RTYPE;
        dec_ctrl.funct     = bus.instr[5:0];
        dec_ctrl.rd        = rd_field;
        dec_ctrl.reg_write = 1'b1;
        dec_b              = rt_val;
      end
      OP_LW, OP_ADDI: begin
        dec_ctrl.rd        = rt;
        dec_ctrl.reg_write = 1'b1;
        dec_b              = imm_sext;
      end
      OP_SW: begin
        dec_b = imm_sext;
      end
      OP_BEQ: begin
        dec_ctrl.alu_op = ALUOP_SUB;
        dec_b           = rt_val;
      end
      default: ;
    endcase
    if (dec_ctrl.rd == '0) begin
      dec_ctrl.reg_write = 1'b0;
    end
  end

  ex_ctrl_t         ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sd_q, sd_d;

  // flush beats stall; an invalid fetch slot captures a bubble
  always_comb begin
    ctrl_d = ctrl_q;
    a_d    = a_q;
    b_d    = b_q;
    sd_d   = sd_q;
    if (bus.flush || (!bus.stall && !bus.if_valid)) begin
      ctrl_d = EX_CTRL_BUBBLE;
      a_d    = '0;
      b_d    = '0;
      sd_d   = '0;
    end else if (!bus.stall) begin
      ctrl_d = dec_ctrl;
      a_d    = rs_val;
      b_d    = dec_b;
      sd_d   = rt_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      a_q    <= '0;
      b_q    <= '0;
      sd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sd_q   <= sd_d;
    end
  end

  assign bus.a             = a_q;
  assign bus.b             = b_q;
  assign bus.Alu_op        = ctrl_q.alu_op;
  assign bus.funct         = ctrl_q.funct;
  assign bus.ex_store_data = sd_q;
  assign bus.ex_rd         = ctrl_q.rd;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_valid      = ctrl_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus random traffic against a
// behavioural model of the register file and decode rules.
module tb_id_ex_stage;

  logic clk;
  logic reset;
  logic chk_en;
  int   n_checks;
  int   n_fail;

  id_ex_stage_if u_if ();

  id_ex_stage u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
  } exp_t;

  logic [31:0] regs [32];
  exp_t        exp_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ID_EX_BYPASS_EN
    if (u_if.wb_we && (u_if.wb_addr == r)) return u_if.wb_data;
`endif
    return regs[r];
  endfunction

  // What the ID/EX register must hold after capturing this instruction.
  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] rsv, rtv, imm;
    rsv     = model_read(ins[25:21]);
    rtv     = model_read(ins[20:16]);
    imm     = {{16{ins[15]}}, ins[15:0]};
    e       = '0;
    e.valid = 1'b1;
    e.a     = rsv;
    e.sd    = rtv;
    case (ins[31:26])
      6'h00: begin e.op = 2'b11; e.b = rtv; e.funct = ins[5:0]; e.rd = ins[15:11]; end
      6'h23, 6'h08: begin e.b = imm; e.rd = ins[20:16]; end
      6'h2B: e.b = imm;
      6'h04: begin e.op = 2'b01; e.b = rtv; end
      default: ;
    endcase
    // Only R-type, lw and addi name a destination; r0 never counts as one.
    e.rw = (e.rd != 5'd0);
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      if (u_if.flush) exp_q <= '0;
      else if (u_if.stall) exp_q <= exp_q;
      else if (!u_if.if_valid) exp_q <= '0;
      else exp_q <= model_decode(u_if.instr);
      if (u_if.wb_we && (u_if.wb_addr != 5'd0)) regs[u_if.wb_addr] <= u_if.wb_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_valid", {31'd0, u_if.ex_valid}, {31'd0, exp_q.valid});
      chk("ex_reg_write", {31'd0, u_if.ex_reg_write}, {31'd0, exp_q.rw});
      chk("ex_rd", {27'd0, u_if.ex_rd}, {27'd0, exp_q.rd});
      chk("Alu_op", {30'd0, u_if.Alu_op}, {30'd0, exp_q.op});
      chk("funct", {26'd0, u_if.funct}, {26'd0, exp_q.funct});
      chk("a", u_if.a, exp_q.a);
      chk("b", u_if.b, exp_q.b);
      chk("ex_store_data", u_if.ex_store_data, exp_q.sd);
    end
  end

  // Applies one cycle of inputs and returns at the following falling edge.
  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rst);
    u_if.instr    = ins;
    u_if.if_valid = v;
    u_if.stall    = st;
    u_if.flush    = fl;
    u_if.wb_we    = we;
    u_if.wb_addr  = wa;
    u_if.wb_data  = wd;
    reset         = rst;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, wa, wd, 1'b0);
  endtask

  task automatic issue(input logic [31:0] ins);
    drive(ins, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0, 1:    op = 6'h00;
      2:       op = 6'h23;
      3:       op = 6'h2B;
      4:       op = 6'h04;
      5:       op = 6'h08;
      default: op = 6'($urandom);
    endcase
    return {op, 26'($urandom)};
  endfunction

  localparam logic [31:0] AddR3R1R2 = 32'h0022_1820;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 5'($urandom), $urandom,
            1'b1);
      chk_en = 1'b1;
    end
    chk("rst_ex_valid", {31'd0, u_if.ex_valid}, 32'd0);
    chk("rst_a", u_if.a, 32'd0);
    chk("rst_ex_rd", {27'd0, u_if.ex_rd}, 32'd0);

    for (int r = 0; r < 32; r++) begin
      issue({6'h00, 5'(r), 5'(31 - r), 5'd7, 5'd0, 6'h20});
      chk("rst_read_rs", u_if.a, 32'd0);
      chk("rst_read_rt", u_if.b, 32'd0);
    end

    wr(5'd1, 32'd57);
    wr(5'd2, 32'd23);
    issue(AddR3R1R2);
    chk("add_a", u_if.a, 32'd57);
    chk("add_b", u_if.b, 32'd23);
    chk("add_op", {30'd0, u_if.Alu_op}, 32'd3);
    chk("add_funct", {26'd0, u_if.funct}, 32'h20);
    chk("add_rd", {27'd0, u_if.ex_rd}, 32'd3);
    chk("add_rw", {31'd0, u_if.ex_reg_write}, 32'd1);
    chk("mdl_add_a", exp_q.a, 32'd57);

    wr(5'd4, 32'h10);
    wr(5'd5, 32'h1234_5678);
    issue(32'h8C85_FFFC);
    chk("lw_a", u_if.a, 32'h10);
    chk("lw_b", u_if.b, 32'hFFFF_FFFC);
    chk("lw_op", {30'd0, u_if.Alu_op}, 32'd0);
    chk("lw_rd", {27'd0, u_if.ex_rd}, 32'd5);
    chk("mdl_lw_b", exp_q.b, 32'hFFFF_FFFC);
    issue(32'hAC85_FFFC);
    chk("sw_rw", {31'd0, u_if.ex_reg_write}, 32'd0);
    chk("sw_sd", u_if.ex_store_data, 32'h1234_5678);
    chk("sw_b", u_if.b, 32'hFFFF_FFFC);

    issue(32'h1022_0003);
    chk("beq_op", {30'd0, u_if.Alu_op}, 32'd1);
    chk("beq_b", u_if.b, 32'd23);
    chk("beq_rw", {31'd0, u_if.ex_reg_write}, 32'd0);

    wr(5'd0, 32'hDEAD);
    issue(32'h0000_1820);
    chk("r0_read", u_if.a, 32'd0);

    // stall: outputs frozen while instr changes and unrelated writes land
    issue(AddR3R1R2);
    for (int i = 0; i < 3; i++) begin
      drive(rand_instr(), 1'b1, 1'b1, 1'b0, 1'b1, 5'($urandom_range(10, 20)), $urandom, 1'b0);
      chk("stall_a", u_if.a, 32'd57);
      chk("stall_rd", {27'd0, u_if.ex_rd}, 32'd3);
    end
    drive(AddR3R1R2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("flush_valid", {31'd0, u_if.ex_valid}, 32'd0);
    chk("flush_a", u_if.a, 32'd0);

    issue(AddR3R1R2);
    drive(AddR3R1R2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("rst_stall_valid", {31'd0, u_if.ex_valid}, 32'd0);
    chk("rst_stall_b", u_if.b, 32'd0);

    // same-cycle writeback while decoding
    wr(5'd1, 32'd57);
    wr(5'd2, 32'd23);
    drive(AddR3R1R2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'd99, 1'b0);
`ifdef ID_EX_BYPASS_EN
    chk("same_cycle_a", u_if.a, 32'd99);
`else
    chk("same_cycle_a", u_if.a, 32'd57);
`endif
    issue(AddR3R1R2);
    chk("after_write_a", u_if.a, 32'd99);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), 1'($urandom), 5'($urandom), $urandom,
            ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage sitting directly upstream of the ALU (Alu_final).
- Holds the 32x32 register file and decodes the IF/ID instruction word.
- Registers the ALU operands and control (a, b, Alu_op, funct) plus EX-side bookkeeping into an ID/EX pipeline register with stall and flush.

Parameters:
- NREGS, 32, number of architectural registers (index width 5).
- WIDTH, 32, datapath width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  instruction word from IF/ID.
- if_valid  input  1  instr is valid this cycle.
- stall  input  1  hold ID/EX register contents.
- flush  input  1  replace next ID/EX contents with a bubble.
- wb_we  input  1  writeback enable.
- wb_addr  input  5  writeback register index.
- wb_data  input  32  writeback data.
- a  output  32  ALU operand A (rs value).
- b  output  32  ALU operand B (rt value or sign-extended imm16).
- Alu_op  output  2  00 = add, 01 = sub, 11 = R-type (ALU decodes funct).
- funct  output  6  instr[5:0] for R-type, else 6'b000000.
- ex_store_data  output  32  rt value, used by sw.
- ex_rd  output  5  destination register.
- ex_reg_write  output  1  EX instruction writes the register file.
- ex_valid  output  1  ID/EX slot holds a real instruction.

Behaviour:
- Latency: 1 cycle from instr to registered outputs. All outputs are registered; none is combinational from inputs.
- Reset (sync): every output goes to 0 and all 32 registers clear to 0. A reset in mid-stall or mid-flush wins over both.
- Per-edge priority: reset > flush > stall > capture.
  - flush: ex_valid = 0, ex_reg_write = 0, a = b = 0, Alu_op = 00, funct = 0, ex_rd = 0.
  - stall: every ID/EX field holds its value.
  - capture: load the decoded fields below. If if_valid = 0, load a bubble, same as flush.
- Register file write: on the edge when wb_we = 1 and wb_addr != 0. Writes to r0 are ignored and r0 always reads 0.
- Register file write during stall: the write still occurs. The held ID/EX values do not change.
- Decode by opcode instr[31:26]:
  - 000000 R-type: Alu_op = 11, b = rt value, ex_rd = instr[15:11], ex_reg_write = 1.
  - 100011 lw and 001000 addi: Alu_op = 00, b = sext(imm16), ex_rd = instr[20:16], ex_reg_write = 1.
  - 101011 sw: Alu_op = 00, b = sext(imm16), ex_reg_write = 0, ex_rd = 0.
  - 000100 beq: Alu_op = 01, b = rt value, ex_reg_write = 0.
  - any other opcode: captured as a bubble with ex_valid = 1 and ex_reg_write = 0 (NOP).
- a = rs value in all cases. ex_store_data = rt value in all cases.
- A destination of 0 forces ex_reg_write = 0.
- Sign extension: bit 15 of imm16 replicated into bits 31:16. Example: 0xFFFF -> 0xFFFFFFFF.

Optional Feature:
- ID_EX_BYPASS_EN defined: write-through read. If wb_we = 1 and wb_addr matches rs or rt (nonzero) in the same cycle, the captured operand is wb_data.
- Not defined: reads return the pre-write array value. The new value is visible from the following cycle.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - Alu_op codes ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE.
  - funct constants F_ADD = 100000, F_SUB = 100010, F_AND = 100100, F_OR = 100101, F_SLT = 101010.
- One sub-module, reg_file: 2 async read ports, 1 sync write port, r0 hardwired to zero, bypass under the macro.
- Decode and the pipeline register stay in id_ex_stage.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> all outputs 0. Afterwards, reading any register returns 0.
- R-type: write r1 = 57 and r2 = 23; then instr add r3,r1,r2 (0x00221820) -> next cycle a = 57, b = 23, Alu_op = 11, funct = 100000, ex_rd = 3, ex_reg_write = 1.
- Immediate: r4 = 0x10, lw r5,-4(r4) (0x8C85FFFC) -> a = 0x10, b = 0xFFFFFFFC, Alu_op = 00, ex_rd = 5. Same for sw (0xAC85FFFC) -> ex_reg_write = 0, ex_store_data = r5.
- beq r1,r2 (0x10220003) -> Alu_op = 01, b = 23, ex_reg_write = 0. Write to r0 of 0xDEAD, then read r0 -> 0.
- Stall 3 cycles while instr changes -> outputs frozen. Assert flush together with stall -> bubble with ex_valid = 0. Assert reset during stall -> all 0.
- Same-cycle write r1 = 99 while decoding add r3,r1,r2 -> a = 99 with ID_EX_BYPASS_EN; a = old r1 value (57) without it.
